// File: rtl/vlw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vlw_pkg
// Description : Shared constants, lane-buffer type and sequencer state
//               encoding for the load-writeback sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package vlw_pkg;

    localparam int LANES       = 16;
    localparam int DW          = 32;
    localparam int AW          = 4;
    localparam int SCALAR_LANE = 15;

    typedef logic [LANES-1:0][DW-1:0] vreg_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } vlw_state_e;

endpackage
`default_nettype wire

// File: rtl/vec_load_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : vec_load_writeback_if
// Description : Request, memory-beat, write-port and busy signals of the
//               load-writeback sequencer. slave = sequencer side.
// Revision    : 1.0  initial release
// ============================================================================
interface vec_load_writeback_if #(
    parameter int LANES = vlw_pkg::LANES,
    parameter int DW    = vlw_pkg::DW,
    parameter int AW    = vlw_pkg::AW
);

    logic                       req_valid;
    logic                       req_ready;
    logic                       req_vec;
    logic [AW-1:0]              req_rd;
    logic                       beat_valid;
    logic                       beat_ready;
    logic [DW-1:0]              beat_data;
    logic                       flush;
    logic                       wb_we;
    logic [AW-1:0]              wb_ra3;
    logic [LANES-1:0][DW-1:0]   wb_wd3;
    logic                       wb_selec_v_s_w;
    logic                       busy;
    logic [AW-1:0]              busy_rd;
    logic                       busy_vec;

    modport slave (
        input  req_valid, req_vec, req_rd, beat_valid, beat_data, flush,
        output req_ready, beat_ready, wb_we, wb_ra3, wb_wd3, wb_selec_v_s_w,
               busy, busy_rd, busy_vec
    );

    modport master (
        output req_valid, req_vec, req_rd, beat_valid, beat_data, flush,
        input  req_ready, beat_ready, wb_we, wb_ra3, wb_wd3, wb_selec_v_s_w,
               busy, busy_rd, busy_vec
    );

endinterface
`default_nettype wire

// File: rtl/vec_load_writeback.sv
`default_nettype none
// ============================================================================
// Module      : vec_load_writeback
// Description : Collects 32-bit memory beats of one scalar/vector load into a
//               16-lane word and issues a single register-file write pulse.
// Revision    : 1.0  initial release
// ============================================================================
module vec_load_writeback #(
    parameter int LANES = vlw_pkg::LANES,
    parameter int DW    = vlw_pkg::DW,
    parameter int AW    = vlw_pkg::AW
) (
    input  wire logic           clk,
    input  wire logic           rst,
    vec_load_writeback_if.slave bus
);
    import vlw_pkg::*;

    localparam int CW = $clog2(LANES);

    vlw_state_e               r_state;
    vlw_state_e               w_state_nxt;
    logic [CW-1:0]            r_cnt;
    logic [LANES-1:0][DW-1:0] r_buf;
    logic [AW-1:0]            r_rd;
    logic                     r_vec;

    logic                     w_req_ready;
    logic                     w_beat_ready;
    logic                     w_wb_we;
    logic                     w_req_hs;
    logic                     w_beat_hs;
    logic                     w_last;
    logic [CW-1:0]            w_lane;

    assign w_req_hs  = bus.req_valid  && w_req_ready;
    assign w_beat_hs = bus.beat_valid && w_beat_ready;
    // Scalar loads finish on their only beat; vectors on the beat at LANES-1.
    assign w_last    = w_beat_hs && (!r_vec || (r_cnt == CW'(LANES - 1)));
    assign w_lane    = r_vec ? r_cnt : CW'(SCALAR_LANE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_req_ready  = 1'b0;
        w_beat_ready = 1'b0;
        w_wb_we      = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (w_req_hs) begin
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                w_beat_ready = 1'b1;
                if (bus.flush) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                // A flush landing on the write cycle cancels the pulse.
                w_wb_we     = !bus.flush;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_buf <= '0;
            r_rd  <= '0;
            r_vec <= 1'b0;
        end else if (w_req_hs) begin
            r_cnt <= '0;
            r_buf <= '0;
            r_rd  <= bus.req_rd;
            r_vec <= bus.req_vec;
        end else if (w_beat_hs && !bus.flush) begin
            r_buf[w_lane] <= bus.beat_data;
            if (r_vec && !w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.req_ready      = w_req_ready;
    assign bus.beat_ready     = w_beat_ready;
    assign bus.wb_we          = w_wb_we;
    assign bus.wb_ra3         = r_rd;
    assign bus.wb_wd3         = r_buf;
    assign bus.wb_selec_v_s_w = r_vec;
    assign bus.busy           = (r_state != IDLE);
    assign bus.busy_rd        = r_rd;
    assign bus.busy_vec       = r_vec;

endmodule
`default_nettype wire

// File: tb/tb_vec_load_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_load_writeback
// Description : Directed self-checking bench; expected writes are queued when
//               a load is driven and compared when wb_we pulses.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vec_load_writeback;
    import vlw_pkg::*;

    typedef struct {
        logic [AW-1:0] rd;
        logic          vec;
        vreg_t         data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;
    int   we_seen = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    vec_load_writeback_if bus ();

    vec_load_writeback dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [LANES*DW-1:0] obs,
                       input logic [LANES*DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.req_valid  = 1'b0;
        bus.req_vec    = 1'b0;
        bus.req_rd     = '0;
        bus.beat_valid = 1'b0;
        bus.beat_data  = '0;
        bus.flush      = 1'b0;
    endtask

    // Scoreboard side: every wb_we pulse must match the oldest queued load.
    always @(negedge clk) begin
        exp_t e;
        if (bus.wb_we === 1'b1) begin
            we_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_we", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("wb_ra3", bus.wb_ra3, e.rd);
                chk("wb_sel", bus.wb_selec_v_s_w, e.vec);
                chk("wb_wd3", bus.wb_wd3, e.data);
            end
        end
    end

    task automatic idle_check(input string tag);
        next_cyc();
        clear_inputs();
        smp();
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_req_ready"}, bus.req_ready, 1);
        chk({tag, "_we"}, bus.wb_we, 0);
    endtask

    task automatic do_scalar(input logic [AW-1:0] rd, input logic [DW-1:0] d,
                             input bit idle_beat, input bit idle_flush);
        exp_t e;
        e.rd   = rd;
        e.vec  = 1'b0;
        e.data = '0;
        e.data[SCALAR_LANE] = d;
        sb.push_back(e);
        next_cyc();
        bus.req_valid  = 1'b1;
        bus.req_vec    = 1'b0;
        bus.req_rd     = rd;
        bus.beat_valid = idle_beat;
        bus.beat_data  = 32'hBAD0_0000 | 32'(rd);
        bus.flush      = idle_flush;
        smp();
        chk("s_req_ready", bus.req_ready, 1);
        chk("s_idle_beat_ready", bus.beat_ready, 0);
        chk("s_idle_busy", bus.busy, 0);
        chk("s_idle_we", bus.wb_we, 0);
        next_cyc();
        bus.req_valid  = 1'b0;
        bus.flush      = 1'b0;
        bus.beat_valid = 1'b1;
        bus.beat_data  = d;
        smp();
        chk("s_busy", bus.busy, 1);
        chk("s_busy_rd", bus.busy_rd, rd);
        chk("s_busy_vec", bus.busy_vec, 0);
        chk("s_beat_ready", bus.beat_ready, 1);
        chk("s_early_we", bus.wb_we, 0);
        next_cyc();
        bus.beat_valid = 1'b0;
        smp();
        chk("s_we", bus.wb_we, 1);
        chk("s_write_req_ready", bus.req_ready, 0);
    endtask

    // flush_at: -1 none, 0..15 together with that beat, 16 during WRITE.
    task automatic do_vector(input logic [AW-1:0] rd, input bit gap, input int flush_at);
        exp_t e;
        int   k;
        bit   toggle;
        e.rd  = rd;
        e.vec = 1'b1;
        for (int i = 0; i < LANES; i++) e.data[i] = 32'(32'h100 + i);
        if (flush_at < 0) sb.push_back(e);
        next_cyc();
        bus.req_valid = 1'b1;
        bus.req_vec   = 1'b1;
        bus.req_rd    = rd;
        smp();
        chk("v_req_ready", bus.req_ready, 1);
        next_cyc();
        bus.req_valid = 1'b0;
        k      = 0;
        toggle = 1'b0;
        while (k < LANES) begin
            if (gap && toggle) begin
                bus.beat_valid = 1'b0;
            end else begin
                bus.beat_valid = 1'b1;
                bus.beat_data  = 32'(32'h100 + k);
            end
            bus.flush = (flush_at == k) && bus.beat_valid;
            smp();
            chk("v_busy", bus.busy, 1);
            chk("v_no_we", bus.wb_we, 0);
            if (bus.beat_valid) chk("v_beat_ready", bus.beat_ready, 1);
            if (bus.flush) return;
            if (bus.beat_valid) k++;
            toggle = ~toggle;
            next_cyc();
        end
        bus.beat_valid = 1'b0;
        bus.flush      = (flush_at == LANES);
        smp();
        chk("v_we", bus.wb_we, (flush_at == LANES) ? 0 : 1);
        chk("v_write_beat_ready", bus.beat_ready, 0);
        chk("v_write_busy", bus.busy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        #2 rst = 1'b0;
        #1;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_beat_ready", bus.beat_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_we", bus.wb_we, 0);
        chk("rst_ra3", bus.wb_ra3, 0);
        chk("rst_wd3", bus.wb_wd3, 0);
        next_cyc();
        rst = 1'b1;

        do_scalar(4'd4, 32'hDEADBEEF, 1'b0, 1'b0);
        idle_check("after_scalar");

        do_vector(4'd2, 1'b0, -1);
        idle_check("after_vec");

        do_vector(4'd3, 1'b1, -1);
        idle_check("after_gap_vec");

        do_vector(4'd5, 1'b0, 9);
        do_scalar(4'd6, 32'hCAFEF00D, 1'b0, 1'b0);
        idle_check("after_flush9");

        do_vector(4'd8, 1'b0, 15);
        idle_check("after_flush_last");

        do_vector(4'd9, 1'b0, 16);
        idle_check("after_flush_write");

        // Reset while beat 5 of a vector load is on the bus.
        next_cyc();
        bus.req_valid = 1'b1;
        bus.req_vec   = 1'b1;
        bus.req_rd    = 4'd7;
        next_cyc();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.beat_valid = 1'b1;
            bus.beat_data  = 32'(32'h200 + i);
            next_cyc();
        end
        bus.beat_data = 32'h205;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_req_ready", bus.req_ready, 1);
        chk("mid_rst_beat_ready", bus.beat_ready, 0);
        chk("mid_rst_we", bus.wb_we, 0);
        chk("mid_rst_ra3", bus.wb_ra3, 0);
        chk("mid_rst_sel", bus.wb_selec_v_s_w, 0);
        chk("mid_rst_busy_rd", bus.busy_rd, 0);
        chk("mid_rst_wd3", bus.wb_wd3, 0);
        next_cyc();
        next_cyc();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("post_rst_we", bus.wb_we, 0);
            chk("post_rst_beat_ready", bus.beat_ready, 0);
            next_cyc();
        end
        clear_inputs();
        smp();
        chk("post_rst_req_ready", bus.req_ready, 1);

        do_scalar(4'd10, 32'h1234_5678, 1'b1, 1'b0);
        do_scalar(4'd11, 32'h9ABC_DEF0, 1'b1, 1'b1);
        idle_check("end");

        chk("we_count", 32'(we_seen), 32'd6);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
